// File: rtl/clk_div_bank.sv
// Bank of runtime-reconfigurable integer clock dividers with a PLL-style lock flag.
// Define CLK_DIV_BANK_FRAC_DIV_EN to add the cfg_frac port and fractional-N period dithering.
module clk_div_bank #(
  parameter int NUM_CLOCKS  = 2,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int LOCK_CYCLES = 16,
  parameter int CH_W        = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic                  locked,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_chan,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W-1:0]      cfg_phase,
`ifdef CLK_DIV_BANK_FRAC_DIV_EN
  input  logic [7:0]            cfg_frac,
`endif
  output logic                  cfg_err
);

  localparam int unsigned NCH = NUM_CLOCKS;
  localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(LOCK_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_RST     = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(1);
  localparam logic [CH_W:0]    NUM_CH      = (CH_W + 1)'(NUM_CLOCKS);

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_LOCKED,
    ST_RECONFIG
  } state_t;

  state_t                  state_q, state_d;
  logic [SET_W-1:0]        settle_q, settle_d;
  logic                    locked_q, locked_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic [NUM_CLOCKS-1:0]   out_q, out_d;
  logic [DIV_W-1:0]        div_q [NUM_CLOCKS];
  logic [DIV_W-1:0]        div_d [NUM_CLOCKS];
  logic [DIV_W-1:0]        ph_q  [NUM_CLOCKS];
  logic [DIV_W-1:0]        ph_d  [NUM_CLOCKS];
  logic [DIV_W-1:0]        cnt_q [NUM_CLOCKS];
  logic [DIV_W-1:0]        cnt_d [NUM_CLOCKS];
  logic [DIV_W-1:0]        lim;
  logic [DIV_W-1:0]        p_eff;
  logic                    req_ok;
`ifdef CLK_DIV_BANK_FRAC_DIV_EN
  logic [7:0]              frac_q [NUM_CLOCKS];
  logic [7:0]              frac_d [NUM_CLOCKS];
  logic [7:0]              acc_q  [NUM_CLOCKS];
  logic [7:0]              acc_d  [NUM_CLOCKS];
  logic [NUM_CLOCKS-1:0]   ext_q, ext_d;
  logic [8:0]              acc_sum;
`endif

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    locked_d = locked_q;
    ready_d  = ready_q;
    err_d    = 1'b0;
    out_d    = out_q;
    div_d    = div_q;
    ph_d     = ph_q;
    cnt_d    = cnt_q;
    lim      = '0;
    p_eff    = '0;
    req_ok   = (cfg_div > DIV_ONE) && ({1'b0, cfg_chan} < NUM_CH);
`ifdef CLK_DIV_BANK_FRAC_DIV_EN
    frac_d  = frac_q;
    acc_d   = acc_q;
    ext_d   = ext_q;
    acc_sum = '0;
`endif

    for (int unsigned i = 0; i < NCH; i++) begin
`ifdef CLK_DIV_BANK_FRAC_DIV_EN
      lim = div_q[i] - DIV_ONE + {{(DIV_W-1){1'b0}}, ext_q[i]};
`else
      lim = div_q[i] - DIV_ONE;
`endif
      out_d[i] = cnt_q[i] < (div_q[i] >> 1);
      if (cnt_q[i] == lim) begin
        cnt_d[i] = '0;
`ifdef CLK_DIV_BANK_FRAC_DIV_EN
        acc_sum  = {1'b0, acc_q[i]} + {1'b0, frac_q[i]};
        acc_d[i] = acc_sum[7:0];
        ext_d[i] = acc_sum[8];
`endif
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end

    unique case (state_q)
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = ST_LOCKED;
          locked_d = 1'b1;
          ready_d  = 1'b1;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (cfg_valid) begin
          if (req_ok) begin
            for (int unsigned i = 0; i < NCH; i++) begin
              if (CH_W'(i) == cfg_chan) begin
                div_d[i]  = cfg_div;
                ph_d[i]   = cfg_phase;
`ifdef CLK_DIV_BANK_FRAC_DIV_EN
                frac_d[i] = cfg_frac;
`endif
              end
            end
            state_d  = ST_RECONFIG;
            locked_d = 1'b0;
            ready_d  = 1'b0;
            out_d    = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RECONFIG: begin
        // Restart edge: the output already reflects the loaded phase, so the
        // only all-low cycle is the RECONFIG cycle itself.
        for (int unsigned i = 0; i < NCH; i++) begin
          p_eff    = (ph_q[i] >= div_q[i]) ? '0 : ph_q[i];
          out_d[i] = p_eff < (div_q[i] >> 1);
          cnt_d[i] = (p_eff == div_q[i] - DIV_ONE) ? '0 : p_eff + 1'b1;
`ifdef CLK_DIV_BANK_FRAC_DIV_EN
          acc_d[i] = '0;
          ext_d[i] = 1'b0;
`endif
        end
        state_d  = ST_SETTLE;
        settle_d = '0;
      end
      default: begin
        state_d  = ST_SETTLE;
        settle_d = '0;
      end
    endcase
  end

  always_ff @(posedge refclk) begin
    if (!rst) begin
      state_q  <= ST_SETTLE;
      settle_q <= '0;
      locked_q <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      out_q    <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        div_q[i] <= DIV_RST;
        ph_q[i]  <= '0;
        cnt_q[i] <= '0;
`ifdef CLK_DIV_BANK_FRAC_DIV_EN
        frac_q[i] <= '0;
        acc_q[i]  <= '0;
`endif
      end
`ifdef CLK_DIV_BANK_FRAC_DIV_EN
      ext_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      locked_q <= locked_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      out_q    <= out_d;
      div_q    <= div_d;
      ph_q     <= ph_d;
      cnt_q    <= cnt_d;
`ifdef CLK_DIV_BANK_FRAC_DIV_EN
      frac_q <= frac_d;
      acc_q  <= acc_d;
      ext_q  <= ext_d;
`endif
    end
  end

  assign outclk    = out_q;
  assign locked    = locked_q;
  assign cfg_ready = ready_q;
  assign cfg_err   = err_q;

endmodule
